// File: rtl/vga_sprite_pkg.sv
// Shared constants for the multi-sprite overlay: register map, address decode, latency.
package vga_sprite_pkg;

  // Sprite register offsets (addr[2:0] inside the register window)
  localparam logic [2:0] REG_EN     = 3'd0;
  localparam logic [2:0] REG_X0     = 3'd1;
  localparam logic [2:0] REG_Y0     = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_PERIOD = 3'd4;
  localparam logic [2:0] REG_PAL1   = 3'd5;
  localparam logic [2:0] REG_PAL2   = 3'd6;
  localparam logic [2:0] REG_PAL3   = 3'd7;

  // Address decode bit positions: addr[13]=0 selects bitmap RAM,
  // addr[13]=1/addr[12]=0 the sprite registers, addr[13]=1/addr[12]=1 the global bit
  localparam int unsigned ADDR_RAM_MSB    = 11;
  localparam int unsigned ADDR_REG_BIT    = 13;
  localparam int unsigned ADDR_GLOBAL_BIT = 12;

  // Position of the auto-animate flag inside the ctrl register
  localparam int unsigned CTRL_AUTO_BIT = 4;

  // Cycles from x/y/si_rgb to so_rgb
  localparam int unsigned PIPE_LATENCY = 2;

endpackage

// File: rtl/vga_sprite_engine.sv
// One sprite: registers, bitmap RAM, hit test, animation counter and two-stage pixel pipe.
module vga_sprite_engine
  import vga_sprite_pkg::*;
#(
  parameter int unsigned    CD        = 12,
  parameter int unsigned    SPR_DIM   = 16,
  parameter int unsigned    FRAMES    = 4,
  parameter int unsigned    RW        = 12,
  parameter logic [CD-1:0]  KEY_COLOR = '0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [10:0]                                 x,
  input  logic [10:0]                                 y,
  input  logic                                        frame_start,
  input  logic                                        ram_we,
  input  logic [$clog2(FRAMES)+2*$clog2(SPR_DIM)-1:0] ram_waddr,
  input  logic [1:0]                                  ram_wdata,
  input  logic                                        reg_we,
  input  logic [2:0]                                  reg_off,
  input  logic [RW-1:0]                               reg_data,
  output logic                                        valid_c,
  output logic [CD-1:0]                               rgb_c
);

  localparam int unsigned DW    = $clog2(SPR_DIM);
  localparam int unsigned FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned LW    = $clog2(FRAMES) + 2 * DW;
  localparam int unsigned DEPTH = FRAMES * SPR_DIM * SPR_DIM;

  logic          en;
  logic [10:0]   x0;
  logic [10:0]   y0;
  logic [7:0]    period;
  logic [CD-1:0] pal [3];
  logic          auto_en;
  logic [FW-1:0] frame;
  logic [7:0]    tick;

  logic [1:0]    ram [DEPTH];
  logic          hit_q;
  logic [1:0]    idx_q;

  logic [11:0]   dx_c;
  logic [11:0]   dy_c;
  logic          hit_c;
  logic [LW-1:0] rd_addr_c;
  logic [FW-1:0] frame_nxt_c;

  // Hit test on 12-bit differences so a sprite near x0=2047 never wraps onto x=0
  always_comb begin
    dx_c        = 12'({1'b0, x}) - 12'({1'b0, x0});
    dy_c        = 12'({1'b0, y}) - 12'({1'b0, y0});
    hit_c       = en && (dx_c < 12'(SPR_DIM)) && (dy_c < 12'(SPR_DIM));
    rd_addr_c   = LW'({frame, dy_c[DW-1:0], dx_c[DW-1:0]});
    frame_nxt_c = (frame == FW'(FRAMES - 1)) ? '0 : frame + FW'(1);
  end

  // Position, enable, period and palette registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en     <= 1'b0;
      x0     <= '0;
      y0     <= '0;
      period <= '0;
      for (int i = 0; i < 3; i++) pal[i] <= '0;
    end else if (reg_we) begin
      case (reg_off)
        REG_EN:     en     <= reg_data[0];
        REG_X0:     x0     <= reg_data[10:0];
        REG_Y0:     y0     <= reg_data[10:0];
        REG_PERIOD: period <= reg_data[7:0];
        REG_PAL1:   pal[0] <= reg_data[CD-1:0];
        REG_PAL2:   pal[1] <= reg_data[CD-1:0];
        REG_PAL3:   pal[2] <= reg_data[CD-1:0];
        default:    ;
      endcase
    end
  end

  // Animation: a ctrl write overrides any advance happening in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_en <= 1'b0;
      frame   <= '0;
      tick    <= '0;
    end else if (reg_we && (reg_off == REG_CTRL)) begin
      auto_en <= reg_data[CTRL_AUTO_BIT];
      frame   <= reg_data[FW-1:0];
      tick    <= '0;
    end else if (frame_start && auto_en) begin
      if (tick == period) begin
        tick  <= '0;
        frame <= frame_nxt_c;
      end else begin
        tick <= tick + 8'd1;
      end
    end
  end

  // Bitmap RAM write port (not reset; contents persist across reset)
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Stage 1: register hit and synchronous RAM read (old data on same-address write)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      hit_q <= hit_c;
      idx_q <= ram[rd_addr_c];
    end
  end

  // Stage 2 palette lookup; index 0 and the key colour are transparent
  always_comb begin
    rgb_c   = pal[0];
    valid_c = 1'b0;
    case (idx_q)
      2'd2:    rgb_c = pal[1];
      2'd3:    rgb_c = pal[2];
      default: rgb_c = pal[0];
    endcase
    valid_c = hit_q && (idx_q != 2'd0) && (rgb_c != KEY_COLOR);
  end

endmodule

// File: rtl/vga_multi_sprite_core.sv
// Multi-sprite overlay: decodes slot writes, detects frame start, and layers sprites over si_rgb.
module vga_multi_sprite_core
  import vga_sprite_pkg::*;
#(
  parameter int unsigned   CD        = 12,
  parameter int unsigned   NUM_SPR   = 4,
  parameter int unsigned   SPR_DIM   = 16,
  parameter int unsigned   FRAMES    = 4,
  parameter logic [CD-1:0] KEY_COLOR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int unsigned DW = $clog2(SPR_DIM);
  localparam int unsigned LW = $clog2(FRAMES) + 2 * DW;
  localparam int unsigned SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int unsigned RW = (CD > 11) ? CD : 11;

  logic          wr_c;
  logic          ram_we_c;
  logic          reg_we_c;
  logic          glb_we_c;
  logic          frame_start_c;
  logic          bypass;
  logic          bypass_d;
  logic [CD-1:0] si_d;
  logic [10:0]   prev_x;
  logic [10:0]   prev_y;
  logic [CD-1:0] pix_c;
  logic          found_c;
  logic          spr_valid_c [NUM_SPR];
  logic [CD-1:0] spr_rgb_c   [NUM_SPR];
  logic          unused_bits;

  assign unused_bits = ^{wr_data[31:RW], addr};

  // Slot decode and frame-start pulse on the transition into (0,0)
  always_comb begin
    wr_c          = cs & write;
    ram_we_c      = wr_c & ~addr[ADDR_REG_BIT];
    reg_we_c      = wr_c &  addr[ADDR_REG_BIT] & ~addr[ADDR_GLOBAL_BIT];
    glb_we_c      = wr_c &  addr[ADDR_REG_BIT] &  addr[ADDR_GLOBAL_BIT];
    frame_start_c = (x == 11'd0) && (y == 11'd0) && ((prev_x != 11'd0) || (prev_y != 11'd0));
  end

  // Previous coordinate, bypass bit and the matching si_rgb/bypass delay stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_x   <= '0;
      prev_y   <= '0;
      bypass   <= 1'b0;
      bypass_d <= 1'b0;
      si_d     <= '0;
    end else begin
      prev_x   <= x;
      prev_y   <= y;
      if (glb_we_c) bypass <= wr_data[0];
      bypass_d <= bypass;
      si_d     <= si_rgb;
    end
  end

  // One engine per sprite
  for (genvar i = 0; i < NUM_SPR; i++) begin : gen_spr
    logic ram_sel_c;
    logic reg_sel_c;
    assign ram_sel_c = (NUM_SPR == 1) || (addr[LW +: SW] == SW'(i));
    assign reg_sel_c = (NUM_SPR == 1) || (addr[3 +: SW] == SW'(i));

    vga_sprite_engine #(
      .CD        (CD),
      .SPR_DIM   (SPR_DIM),
      .FRAMES    (FRAMES),
      .RW        (RW),
      .KEY_COLOR (KEY_COLOR)
    ) u_engine (
      .clk         (clk),
      .reset       (reset),
      .x           (x),
      .y           (y),
      .frame_start (frame_start_c),
      .ram_we      (ram_we_c & ram_sel_c),
      .ram_waddr   (addr[LW-1:0]),
      .ram_wdata   (wr_data[1:0]),
      .reg_we      (reg_we_c & reg_sel_c),
      .reg_off     (addr[2:0]),
      .reg_data    (wr_data[RW-1:0]),
      .valid_c     (spr_valid_c[i]),
      .rgb_c       (spr_rgb_c[i])
    );
  end

  // Priority mux: lowest-numbered visible sprite wins, else upstream pixel
  always_comb begin
    pix_c   = si_d;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      if (!found_c && spr_valid_c[i]) begin
        pix_c   = spr_rgb_c[i];
        found_c = 1'b1;
      end
    end
  end

  // Stage 2 output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) so_rgb <= '0;
    else       so_rgb <= bypass_d ? si_d : pix_c;
  end

endmodule

// File: tb/tb_vga_multi_sprite_core.sv
// Directed scoreboard bench for vga_multi_sprite_core.
module tb_vga_multi_sprite_core;
  import vga_sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = 11'd2000;
  logic [10:0] y = 11'd1000;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] si_rgb = '0;
  logic [11:0] so_rgb;

  typedef struct {
    int unsigned due;
    logic [11:0] exp;
    string       tag;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  vga_multi_sprite_core dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .cs      (cs),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .si_rgb  (si_rgb),
    .so_rgb  (so_rgb)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: compare so_rgb just after the edge an entry falls due
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        n_tests++;
        assert (so_rgb === e.exp) else begin
          n_fail++;
          $error("FAIL %s: so_rgb=%h expected %h", e.tag, so_rgb, e.exp);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] ra(input int s, input int off);
    return 14'(32'h2000 + s * 8 + off);
  endfunction

  function automatic logic [13:0] ma(input int s, input int f, input int r, input int c);
    return 14'(s * 1024 + f * 256 + r * 16 + c);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic do_wr, input logic [13:0] a, input logic [31:0] d,
                      input logic [10:0] px, input logic [10:0] py, input logic [11:0] si,
                      input bit chk, input logic [11:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    cs = do_wr; write = do_wr; addr = a; wr_data = d;
    x = px; y = py; si_rgb = si;
    if (chk) begin
      e.due = cyc + PIPE_LATENCY; e.exp = exp; e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    step(1'b1, a, d, 11'd2000, 11'd1000, 12'h000, 1'b0, 12'h000, "");
  endtask

  task automatic pix(input logic [10:0] px, input logic [10:0] py, input logic [11:0] si,
                     input logic [11:0] exp, input string tag);
    step(1'b0, 14'd0, 32'd0, px, py, si, 1'b1, exp, tag);
  endtask

  task automatic fs();
    step(1'b0, 14'd0, 32'd0, 11'd0, 11'd0, 12'h555, 1'b0, 12'h000, "");
  endtask

  task automatic sprite_cfg(input int s, input int x0, input int y0, input logic [11:0] p1);
    wr(ra(s, 1), 32'(x0));
    wr(ra(s, 2), 32'(y0));
    wr(ra(s, 5), 32'(p1));
    wr(ra(s, 0), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_so", 32'(so_rgb), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Bitmaps: sprite 0 frames 0..3 hold indices 1,2,3,0; sprite 1 frame 0 holds 1
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          wr(ma(0, f, r, c), (f == 3) ? 32'd0 : 32'(f + 1));
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        wr(ma(1, 0, r, c), 32'd1);

    // Single sprite hit and window edges
    sprite_cfg(0, 100, 50, 12'hF00);
    pix(100, 50, 12'h0AA, 12'hF00, "hit_origin");
    pix(116, 50, 12'h0AA, 12'h0AA, "right_edge_miss");
    pix(115, 65, 12'h0AA, 12'hF00, "far_corner_hit");
    pix(99, 50, 12'h0AA, 12'h0AA, "left_miss");
    pix(100, 66, 12'h0AA, 12'h0AA, "below_miss");

    // Priority between overlapping sprites, transparency and key colour
    sprite_cfg(0, 10, 10, 12'h00F);
    sprite_cfg(1, 10, 10, 12'h0F0);
    pix(12, 13, 12'h123, 12'h00F, "prio_spr0");
    wr(ma(0, 0, 3, 2), 32'd0);
    pix(12, 13, 12'h123, 12'h0F0, "prio_transparent");
    step(1'b1, ma(0, 0, 3, 3), 32'd0, 11'd13, 11'd13, 12'h123, 1'b1, 12'h00F, "rbw_old");
    pix(13, 13, 12'h123, 12'h0F0, "rbw_new");
    wr(ra(0, 5), 32'h000);
    pix(14, 13, 12'h123, 12'h0F0, "key_color");
    wr(ra(0, 5), 32'h00F);
    wr(ra(1, 0), 32'd0);

    // No wrap near x0=2047, and global bypass
    wr(ra(0, 1), 32'd2040);
    pix(5, 10, 12'h321, 12'h321, "no_wrap_hit");
    pix(2045, 10, 12'h321, 12'h00F, "edge_hit");
    wr(14'h3000, 32'd1);
    pix(2045, 10, 12'h321, 12'h321, "bypass_on");
    wr(14'h3000, 32'd0);
    pix(2045, 10, 12'h321, 12'h00F, "bypass_off");

    // Animation: frame 3 shows si (index 0), frames 0/1/2 show F00/0F0/00F
    sprite_cfg(0, 100, 50, 12'hF00);
    wr(ra(0, 6), 32'h0F0);
    wr(ra(0, 7), 32'h00F);
    wr(ra(0, 4), 32'd2);
    wr(ra(0, 3), 32'h13);
    pix(100, 50, 12'h555, 12'h555, "anim_f3");
    fs(); pix(100, 50, 12'h555, 12'h555, "anim_tick1");
    fs(); pix(100, 50, 12'h555, 12'h555, "anim_tick2");
    fs(); pix(100, 50, 12'h555, 12'hF00, "anim_wrap");
    wr(ra(0, 4), 32'd0);
    fs(); pix(100, 50, 12'h555, 12'h0F0, "p0_adv");
    fs(); fs(); pix(100, 50, 12'h555, 12'h00F, "p0_single_pulse");
    wr(ra(0, 3), 32'h02);
    fs(); pix(100, 50, 12'h555, 12'h00F, "auto_off_hold");

    // Ctrl write coinciding with an advance
    wr(ra(0, 4), 32'd1);
    wr(ra(0, 3), 32'h12);
    fs(); pix(100, 50, 12'h555, 12'h00F, "pre_collide");
    step(1'b1, ra(0, 3), 32'h11, 11'd0, 11'd0, 12'h555, 1'b0, 12'h000, "");
    pix(100, 50, 12'h555, 12'h0F0, "ctrl_wins");
    fs(); pix(100, 50, 12'h555, 12'h0F0, "tick_cleared");
    fs(); pix(100, 50, 12'h555, 12'h00F, "adv_after_ctrl");

    // Mid-line reset with an active sprite and bypass set
    wr(ra(0, 3), 32'h00);
    pix(100, 50, 12'h0AA, 12'hF00, "pre_reset");
    wr(14'h3000, 32'd1);
    step(1'b0, 14'd0, 32'd0, 11'd101, 11'd50, 12'h0AA, 1'b0, 12'h000, "");
    step(1'b0, 14'd0, 32'd0, 11'd102, 11'd50, 12'h0AA, 1'b0, 12'h000, "");
    step(1'b0, 14'd0, 32'd0, 11'd103, 11'd50, 12'h0AA, 1'b0, 12'h000, "");
    @(posedge clk);
    #3 check("pre_reset_out", 32'(so_rgb), 32'h0AA);
    reset = 1'b1;
    #1 check("reset_async", 32'(so_rgb), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pix(100, 50, 12'h0AA, 12'h0AA, "spr_disabled");
    sprite_cfg(0, 100, 50, 12'hF00);
    pix(100, 50, 12'h0AA, 12'hF00, "ram_kept");
    pix(105, 52, 12'h0AA, 12'hF00, "ram_kept2");

    repeat (4) step(1'b0, 14'd0, 32'd0, 11'd2000, 11'd1000, 12'h000, 1'b0, 12'h000, "");
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
